mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates one single-port synchronous RAM between three requesters:
- 0 = instruction fetch, driven in the FETCH phase.
- 1 = data access, driven in the EXEC1/EXEC2 phases.
- 2 = IO/loader port.

The block sequences each access through a programmable number of wait states and returns a one-cycle ACK with registered read data. The CPU state machine stalls on ACK. The block sits between the CPU/IO requesters and the RAM macro.

Parameters:
AW, 11, address width
DW, 16, data width
WAIT, 1, wait states per access (0..15); each access occupies WAIT+1 RAM cycles

Ports:
CLK  input  1  clock, rising-edge
RST_N  input  1  asynchronous reset, active-low
REQ  input  3  request per requester, bit i = requester i
WE  input  3  write enable per requester, sampled with REQ
ADDR_IN  input  3*AW  addresses; requester i at [i*AW +: AW]
WDATA_IN  input  3*DW  write data; requester i at [i*DW +: DW]
GNT  output  3  one-hot grant, held for the whole access
ACK  output  3  one-hot, one-cycle completion pulse
RDATA  output  DW  registered read data, valid while ACK is high and held until the next ACK
BUSY  output  1  high in ACCESS and DONE
MEM_ADDR  output  AW  RAM address
MEM_WDATA  output  DW  RAM write data
MEM_WE  output  1  RAM write strobe
MEM_RDATA  input  DW  RAM read data

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; GNT=0, ACK=0, RDATA=0, BUSY=0, MEM_ADDR=0, MEM_WDATA=0, MEM_WE=0; round-robin pointer=0; wait counter=0. Reset mid-access aborts the access with no ACK, and MEM_WE drops immediately.
- FSM states: IDLE, ACCESS, DONE. All registers update on rising CLK.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the winner by rotating priority: search pointer, pointer+1, pointer+2 (mod 3).
  - Latch the winner's index, ADDR, WDATA and WE.
  - Load counter=WAIT, go to ACCESS.
- ACCESS:
  - GNT[winner]=1 and BUSY=1.
  - MEM_ADDR and MEM_WDATA are driven from the latched values and stay stable for every ACCESS cycle.
  - MEM_WE = latched WE, asserted only in the final ACCESS cycle (counter==0).
  - If counter!=0, decrement it.
  - If counter==0: capture MEM_RDATA into RDATA (read only; on a write, RDATA is unchanged), go to DONE.
- DONE:
  - ACK[winner]=1 for exactly this cycle; GNT=0; BUSY=1.
  - pointer = (winner+1) mod 3; go to IDLE.
- Latency: from the edge that samples REQ in IDLE, GNT rises the next cycle and ACK rises WAIT+1 cycles after GNT.
- Throughput: one access per WAIT+3 cycles. IDLE is a mandatory one-cycle turnaround.
- RAM read timing: the RAM must return data within WAIT+1 cycles of the address. WAIT=0 is legal only with a combinational-read RAM.
- Requester obligations:
  - ADDR, WDATA and WE need only be valid in the cycle REQ is sampled in IDLE; they are latched.
  - REQ must stay high until ACK to retain priority.
- Boundary conditions:
  - REQ dropped mid-access: the access still completes and ACK still pulses.
  - REQ held high after ACK is a new request; it is arbitrated in the next IDLE.
  - Pointer wraps 2 -> 0.
  - A requester asserting REQ while another holds GNT waits; there is no pre-emption.
  - Never more than one bit of GNT or ACK is high.
  - GNT and ACK are never high in the same cycle.

Optional Feature:
Macro FETCH_PRIO_EN.
- Defined: requester 0 wins whenever REQ[0]=1 in IDLE. Requesters 1 and 2 round-robin among themselves; the pointer only rotates on grants to 1 or 2.
- Undefined: pure three-way round-robin as above.

Test Plan:
- Reset mid-access: WAIT=2, REQ=001 granted, RST_N low during ACCESS -> all outputs 0 asynchronously, no ACK; after release, IDLE with pointer=0.
- Single read: WAIT=1, REQ=001, ADDR0=0x005, RAM[5]=0xBEEF -> GNT=001 for 2 cycles, then ACK=001 for 1 cycle with RDATA=0xBEEF, MEM_WE never high.
- Single write: REQ=010, WE=010, ADDR1=0x07F, WDATA1=0x1234 -> MEM_WE high exactly 1 cycle (the final ACCESS cycle) with MEM_ADDR=0x07F and MEM_WDATA=0x1234; ACK=010; RDATA unchanged.
- Round-robin: REQ=111 held, pointer=0 -> grant order 0,1,2,0, each ACK spaced WAIT+3 cycles apart (FETCH_PRIO_EN undefined).
- FETCH_PRIO_EN defined, REQ=111 held -> requester 0 granted every access; with REQ=110 -> order 1,2,1.
- WAIT=0 with REQ withdrawn after 1 cycle: GNT for 1 cycle -> ACK still pulses; ACK and GNT never overlap.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the requester-side handshake and the RAM-side bus of mem_arbiter.
//
//   Requester side : req[2:0], we[2:0], addr_in[3*AW], wdata_in[3*DW]  (in)
//                    gnt[2:0], ack[2:0], rdata[DW], busy                (out)
//   RAM side       : mem_addr[AW], mem_wdata[DW], mem_we                (out)
//                    mem_rdata[DW]                                      (in)
//
//   Modports:
//     slave  - the arbiter itself
//     master - the requesters (CPU fetch, CPU data, IO/loader)
//     ram    - the RAM macro attached behind the arbiter
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 16
) ();

  logic [2:0]      req;
  logic [2:0]      we;
  logic [3*AW-1:0] addr_in;
  logic [3*DW-1:0] wdata_in;
  logic [2:0]      gnt;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  req, we, addr_in, wdata_in, mem_rdata,
    output gnt, ack, rdata, busy, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr_in, wdata_in,
    input  gnt, ack, rdata, busy
  );

  modport ram (
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous RAM between three requesters:
//     0 = instruction fetch, 1 = data access, 2 = IO/loader.
//   Each access is latched in IDLE, held on the RAM bus for WAIT+1 cycles
//   (ACCESS), then acknowledged with a one-cycle ACK (DONE). IDLE is always
//   a one-cycle turnaround, so one access completes every WAIT+3 cycles.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - mem_arbiter_if.slave: requester REQ/WE/ADDR/WDATA in,
//            GNT/ACK/RDATA/BUSY out, RAM MEM_ADDR/MEM_WDATA/MEM_WE out,
//            MEM_RDATA in
//
// Parameters:
//   AW   - address width
//   DW   - data width
//   WAIT - wait states per access (0..15); WAIT=0 needs a combinational RAM
//
// Build option:
//   FETCH_PRIO_EN - when defined, requester 0 wins every arbitration it takes
//                   part in; requesters 1 and 2 rotate between themselves and
//                   the pointer only moves on grants to 1 or 2. When undefined,
//                   plain three-way round-robin.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW   = 11,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    win_q,   win_d;
  logic [1:0]    ptr_q,   ptr_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          we_q,    we_d;
  logic [3:0]    cnt_q,   cnt_d;

  logic [AW-1:0] req_addr  [3];
  logic [DW-1:0] req_wdata [3];
  wire  [2:0]    gnt_w;
  wire  [2:0]    ack_w;

  logic          req_found;
  logic [1:0]    req_win;

  // Per-requester views of the packed buses, plus the one-hot decode of the
  // latched winner onto GNT (ACCESS) and ACK (DONE). Because the two decodes
  // are qualified by different states they can never overlap.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_req
      assign req_addr[gi]  = bus.addr_in[gi*AW +: AW];
      assign req_wdata[gi] = bus.wdata_in[gi*DW +: DW];
      assign gnt_w[gi]     = (state_q == ACCESS) && (win_q == 2'(gi));
      assign ack_w[gi]     = (state_q == DONE)   && (win_q == 2'(gi));
    end
  endgenerate

`ifndef FETCH_PRIO_EN
  // Index base+k, wrapped into 0..2.
  function automatic logic [1:0] rot3(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction
`endif

  // Winner selection, evaluated every cycle but only used in IDLE.
  always_comb begin
    req_found = 1'b0;
    req_win   = 2'd0;
`ifdef FETCH_PRIO_EN
    if (bus.req[0]) begin
      req_found = 1'b1;
      req_win   = 2'd0;
    end else if (ptr_q == 2'd2) begin
      // Pointer at 2: requester 2 searched first.
      if (bus.req[2]) begin
        req_found = 1'b1;
        req_win   = 2'd2;
      end else if (bus.req[1]) begin
        req_found = 1'b1;
        req_win   = 2'd1;
      end
    end else begin
      // Pointer at 0 or 1: requester 1 searched first.
      if (bus.req[1]) begin
        req_found = 1'b1;
        req_win   = 2'd1;
      end else if (bus.req[2]) begin
        req_found = 1'b1;
        req_win   = 2'd2;
      end
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (!req_found && bus.req[rot3(ptr_q, 2'(k))]) begin
        req_found = 1'b1;
        req_win   = rot3(ptr_q, 2'(k));
      end
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_found) begin
          // Requester inputs are only guaranteed valid now, so latch them.
          win_d   = req_win;
          addr_d  = req_addr[req_win];
          wdata_d = req_wdata[req_win];
          we_d    = bus.we[req_win];
          cnt_d   = 4'(WAIT);
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final RAM cycle: read data is valid now; writes leave RDATA alone.
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = DONE;
        end
      end

      DONE: begin
`ifdef FETCH_PRIO_EN
        // Fetch grants bypass the rotation entirely.
        if (win_q != 2'd0) begin
          ptr_d = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
        end
`else
        ptr_d = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      ptr_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // clears all of them (including MEM_WE) without waiting for a clock edge.
  assign bus.gnt       = gnt_w;
  assign bus.ack       = ack_w;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state_q == ACCESS) && (cnt_q == 4'd0) && we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(11), .DW(16)) ifw0 ();
  mem_arbiter_if #(.AW(11), .DW(16)) ifw1 ();
  mem_arbiter_if #(.AW(11), .DW(16)) ifw2 ();

  mem_arbiter #(.AW(11), .DW(16), .WAIT(0)) dut_w0 (.clk(clk), .rst_n(rst_n), .bus(ifw0));
  mem_arbiter #(.AW(11), .DW(16), .WAIT(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(ifw1));
  mem_arbiter #(.AW(11), .DW(16), .WAIT(2)) dut_w2 (.clk(clk), .rst_n(rst_n), .bus(ifw2));

  // RAM models: ram0 combinational read (for WAIT=0), ram1/ram2 registered read.
  logic [15:0] ram0 [2048];
  logic [15:0] ram1 [2048];
  logic [15:0] ram2 [2048];
  logic        pre_en;
  logic [1:0]  pre_sel;
  logic [10:0] pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_en && pre_sel == 2'd0) ram0[pre_addr] <= pre_data;
    else if (ifw0.mem_we) ram0[ifw0.mem_addr] <= ifw0.mem_wdata;
  end
  assign ifw0.mem_rdata = ram0[ifw0.mem_addr];

  always @(posedge clk) begin
    if (pre_en && pre_sel == 2'd1) ram1[pre_addr] <= pre_data;
    else if (ifw1.mem_we) ram1[ifw1.mem_addr] <= ifw1.mem_wdata;
    ifw1.mem_rdata <= ram1[ifw1.mem_addr];
  end

  always @(posedge clk) begin
    if (pre_en && pre_sel == 2'd2) ram2[pre_addr] <= pre_data;
    else if (ifw2.mem_we) ram2[ifw2.mem_addr] <= ifw2.mem_wdata;
    ifw2.mem_rdata <= ram2[ifw2.mem_addr];
  end

  task automatic preload(input logic [1:0] sel, input logic [10:0] a, input logic [15:0] d);
    pre_sel  = sel;
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Ack log filled by collect_acks on dut_w1.
  logic [2:0]  ack_log [8];
  logic [15:0] rd_log  [8];
  int          cyc_log [8];
  int          ack_cnt;

  task automatic collect_acks(input logic [2:0] reqv, input int n);
    int cyc;
    cyc     = 0;
    ack_cnt = 0;
    ifw1.req = reqv;
    ifw1.we  = 3'b000;
    while (ack_cnt < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (!$onehot0(ifw1.gnt) || !$onehot0(ifw1.ack) || (ifw1.gnt != 3'b000 && ifw1.ack != 3'b000)) begin
        failures++;
        $display("FAIL rr_overlap cycle=%0d gnt=%b ack=%b required onehot0 and disjoint", cyc, ifw1.gnt, ifw1.ack);
      end
      if (ifw1.ack != 3'b000) begin
        ack_log[ack_cnt] = ifw1.ack;
        rd_log[ack_cnt]  = ifw1.rdata;
        cyc_log[ack_cnt] = cyc;
        $display("txn w1 ack=%b rdata=%h cycle=%0d", ifw1.ack, ifw1.rdata, cyc);
        ack_cnt++;
        if (ack_cnt == n) ifw1.req = 3'b000;
      end
    end
    ifw1.req = 3'b000;
    checks++;
    if (ack_cnt != n) begin
      failures++;
      $display("FAIL rr_timeout acks=%0d required=%0d", ack_cnt, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    preload(2'd1, 11'h005, 16'hBEEF);
    preload(2'd1, 11'h020, 16'h2222);
    preload(2'd0, 11'h003, 16'hCAFE);
    preload(2'd2, 11'h009, 16'hABCD);
    preload(2'd2, 11'h00A, 16'h1111);
    checks++; if (ifw1.gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", ifw1.gnt); end
    checks++; if (ifw1.ack !== 3'b000) begin failures++; $display("FAIL reset_ack got=%b exp=000", ifw1.ack); end
    checks++; if (ifw1.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifw1.busy); end
    checks++; if (ifw1.rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", ifw1.rdata); end
    checks++; if (ifw1.mem_we !== 1'b0 || ifw1.mem_addr !== 11'h000 || ifw1.mem_wdata !== 16'h0000) begin
      failures++; $display("FAIL reset_mem we=%b addr=%h wdata=%h exp 0/000/0000", ifw1.mem_we, ifw1.mem_addr, ifw1.mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ifw1.busy !== 1'b0 || ifw1.gnt !== 3'b000) begin failures++; $display("FAIL reset_idle busy=%b gnt=%b exp 0/000", ifw1.busy, ifw1.gnt); end
    $display("txn reset released");
  endtask

  task automatic test_single_read();
    logic [2:0] eg, ea;
    ifw1.req = 3'b001;
    ifw1.we  = 3'b000;
    ifw1.addr_in[0 +: 11] = 11'h005;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      eg = (k <= 2) ? 3'b001 : 3'b000;
      ea = (k == 3) ? 3'b001 : 3'b000;
      checks++; if (ifw1.gnt !== eg) begin failures++; $display("FAIL read_gnt cycle=%0d got=%b exp=%b", k, ifw1.gnt, eg); end
      checks++; if (ifw1.ack !== ea) begin failures++; $display("FAIL read_ack cycle=%0d got=%b exp=%b", k, ifw1.ack, ea); end
      checks++; if (ifw1.mem_we !== 1'b0) begin failures++; $display("FAIL read_mem_we cycle=%0d got=%b exp=0", k, ifw1.mem_we); end
      if (k == 1) begin
        checks++; if (ifw1.mem_addr !== 11'h005) begin failures++; $display("FAIL read_addr got=%h exp=005", ifw1.mem_addr); end
      end
      if (k == 3) begin
        checks++; if (ifw1.rdata !== 16'hBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=BEEF", ifw1.rdata); end
        checks++; if (ifw1.busy !== 1'b1) begin failures++; $display("FAIL read_busy_done got=%b exp=1", ifw1.busy); end
        ifw1.req = 3'b000;
      end
      if (k == 4) begin
        checks++; if (ifw1.busy !== 1'b0) begin failures++; $display("FAIL read_busy_idle got=%b exp=0", ifw1.busy); end
      end
    end
    $display("txn w1 read addr=005 rdata=%h", ifw1.rdata);
  endtask

  task automatic test_single_write();
    int we_cycles;
    we_cycles = 0;
    ifw1.req = 3'b010;
    ifw1.we  = 3'b010;
    ifw1.addr_in[11 +: 11]  = 11'h07F;
    ifw1.wdata_in[16 +: 16] = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (ifw1.mem_we !== (k == 2)) begin failures++; $display("FAIL write_we cycle=%0d got=%b exp=%b", k, ifw1.mem_we, (k == 2)); end
      if (ifw1.mem_we === 1'b1) begin
        we_cycles++;
        checks++; if (ifw1.mem_addr !== 11'h07F || ifw1.mem_wdata !== 16'h1234) begin
          failures++; $display("FAIL write_bus addr=%h wdata=%h exp 07F/1234", ifw1.mem_addr, ifw1.mem_wdata);
        end
      end
      if (k == 3) begin
        checks++; if (ifw1.ack !== 3'b010) begin failures++; $display("FAIL write_ack got=%b exp=010", ifw1.ack); end
        checks++; if (ifw1.rdata !== 16'hBEEF) begin failures++; $display("FAIL write_rdata_held got=%h exp=BEEF", ifw1.rdata); end
        ifw1.req = 3'b000;
        ifw1.we  = 3'b000;
      end
    end
    checks++; if (we_cycles != 1) begin failures++; $display("FAIL write_we_count got=%0d exp=1", we_cycles); end
    checks++; if (ram1[11'h07F] !== 16'h1234) begin failures++; $display("FAIL write_ram got=%h exp=1234", ram1[11'h07F]); end
    $display("txn w1 write addr=07F wdata=1234");
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ack [4];
    logic [15:0] exp_rd  [4];
    // Requester 2 access moves the pointer to 0.
    ifw1.req = 3'b100;
    ifw1.we  = 3'b000;
    ifw1.addr_in[0  +: 11] = 11'h005;
    ifw1.addr_in[11 +: 11] = 11'h07F;
    ifw1.addr_in[22 +: 11] = 11'h020;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    checks++; if (ifw1.ack !== 3'b100 || ifw1.rdata !== 16'h2222) begin
      failures++; $display("FAIL rr_pre ack=%b rdata=%h exp 100/2222", ifw1.ack, ifw1.rdata);
    end
    ifw1.req = 3'b000;
    @(negedge clk);

    collect_acks(3'b111, 4);
`ifdef FETCH_PRIO_EN
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b001; exp_ack[2] = 3'b001; exp_ack[3] = 3'b001;
    exp_rd[0]  = 16'hBEEF; exp_rd[1] = 16'hBEEF; exp_rd[2] = 16'hBEEF; exp_rd[3] = 16'hBEEF;
`else
    exp_ack[0] = 3'b001; exp_ack[1] = 3'b010; exp_ack[2] = 3'b100; exp_ack[3] = 3'b001;
    exp_rd[0]  = 16'hBEEF; exp_rd[1] = 16'h1234; exp_rd[2] = 16'h2222; exp_rd[3] = 16'hBEEF;
`endif
    for (int i = 0; i < 4 && i < ack_cnt; i++) begin
      checks++; if (ack_log[i] !== exp_ack[i]) begin failures++; $display("FAIL rr_order idx=%0d got=%b exp=%b", i, ack_log[i], exp_ack[i]); end
      checks++; if (rd_log[i] !== exp_rd[i]) begin failures++; $display("FAIL rr_rdata idx=%0d got=%h exp=%h", i, rd_log[i], exp_rd[i]); end
      checks++; if (cyc_log[i] != 3 + 4 * i) begin failures++; $display("FAIL rr_spacing idx=%0d got=%0d exp=%0d", i, cyc_log[i], 3 + 4 * i); end
    end

`ifdef FETCH_PRIO_EN
    collect_acks(3'b110, 3);
    exp_ack[0] = 3'b010; exp_ack[1] = 3'b100; exp_ack[2] = 3'b010;
    for (int i = 0; i < 3 && i < ack_cnt; i++) begin
      checks++; if (ack_log[i] !== exp_ack[i]) begin failures++; $display("FAIL prio_order idx=%0d got=%b exp=%b", i, ack_log[i], exp_ack[i]); end
    end
`endif
  endtask

  task automatic test_no_preempt();
    ifw1.req = 3'b001;
    ifw1.we  = 3'b000;
    @(negedge clk);
    checks++; if (ifw1.gnt !== 3'b001) begin failures++; $display("FAIL nopre_gnt1 got=%b exp=001", ifw1.gnt); end
    ifw1.req = 3'b101;
    @(negedge clk);
    checks++; if (ifw1.gnt !== 3'b001) begin failures++; $display("FAIL nopre_gnt2 got=%b exp=001", ifw1.gnt); end
    @(negedge clk);
    checks++; if (ifw1.ack !== 3'b001 || ifw1.gnt !== 3'b000) begin failures++; $display("FAIL nopre_ack0 ack=%b gnt=%b exp 001/000", ifw1.ack, ifw1.gnt); end
    ifw1.req = 3'b100;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ifw1.gnt !== 3'b100) begin failures++; $display("FAIL nopre_gnt_next got=%b exp=100", ifw1.gnt); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (ifw1.ack !== 3'b100 || ifw1.rdata !== 16'h2222) begin failures++; $display("FAIL nopre_ack2 ack=%b rdata=%h exp 100/2222", ifw1.ack, ifw1.rdata); end
    ifw1.req = 3'b000;
    @(negedge clk);
    $display("txn w1 no-preempt 0 then 2");
  endtask

  task automatic test_wait0();
    ifw0.req = 3'b001;
    ifw0.we  = 3'b000;
    ifw0.addr_in[0 +: 11] = 11'h003;
    @(negedge clk);
    checks++; if (ifw0.gnt !== 3'b001 || ifw0.ack !== 3'b000) begin failures++; $display("FAIL w0_gnt gnt=%b ack=%b exp 001/000", ifw0.gnt, ifw0.ack); end
    ifw0.req = 3'b000;
    @(negedge clk);
    checks++; if (ifw0.ack !== 3'b001 || ifw0.gnt !== 3'b000) begin failures++; $display("FAIL w0_ack ack=%b gnt=%b exp 001/000", ifw0.ack, ifw0.gnt); end
    checks++; if (ifw0.rdata !== 16'hCAFE) begin failures++; $display("FAIL w0_rdata got=%h exp=CAFE", ifw0.rdata); end
    @(negedge clk);
    checks++; if (ifw0.ack !== 3'b000 || ifw0.gnt !== 3'b000 || ifw0.busy !== 1'b0) begin
      failures++; $display("FAIL w0_idle ack=%b gnt=%b busy=%b exp 000/000/0", ifw0.ack, ifw0.gnt, ifw0.busy);
    end
    $display("txn w0 read addr=003 rdata=%h", ifw0.rdata);
  endtask

  task automatic test_reset_mid_access();
    int wait_cyc;
    // Completed read first, leaving the pointer at 1.
    ifw2.req = 3'b001;
    ifw2.we  = 3'b000;
    ifw2.addr_in[0 +: 11] = 11'h009;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    checks++; if (ifw2.ack !== 3'b001 || ifw2.rdata !== 16'hABCD) begin failures++; $display("FAIL w2_read ack=%b rdata=%h exp 001/ABCD", ifw2.ack, ifw2.rdata); end
    ifw2.req = 3'b000;
    @(negedge clk);
    // Write that gets aborted in its final ACCESS cycle.
    ifw2.req = 3'b001;
    ifw2.we  = 3'b001;
    ifw2.addr_in[0 +: 11]  = 11'h00A;
    ifw2.wdata_in[0 +: 16] = 16'h5555;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (ifw2.gnt !== 3'b001) begin failures++; $display("FAIL w2_gnt cycle=%0d got=%b exp=001", k, ifw2.gnt); end
    end
    checks++; if (ifw2.mem_we !== 1'b1) begin failures++; $display("FAIL w2_we_before got=%b exp=1", ifw2.mem_we); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifw2.gnt !== 3'b000 || ifw2.ack !== 3'b000 || ifw2.busy !== 1'b0) begin
      failures++; $display("FAIL rst_async_ctl gnt=%b ack=%b busy=%b exp 000/000/0", ifw2.gnt, ifw2.ack, ifw2.busy);
    end
    checks++; if (ifw2.mem_we !== 1'b0 || ifw2.mem_addr !== 11'h000 || ifw2.mem_wdata !== 16'h0000 || ifw2.rdata !== 16'h0000) begin
      failures++; $display("FAIL rst_async_data we=%b addr=%h wdata=%h rdata=%h exp all 0", ifw2.mem_we, ifw2.mem_addr, ifw2.mem_wdata, ifw2.rdata);
    end
    ifw2.req = 3'b000;
    ifw2.we  = 3'b000;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (ifw2.ack !== 3'b000) begin failures++; $display("FAIL rst_no_ack cycle=%0d got=%b exp=000", k, ifw2.ack); end
    end
    rst_n = 1'b1;
    checks++; if (ram2[11'h00A] !== 16'h1111) begin failures++; $display("FAIL rst_ram_untouched got=%h exp=1111", ram2[11'h00A]); end
    ifw2.req = 3'b111;
    @(negedge clk);
    checks++; if (ifw2.gnt !== 3'b001) begin failures++; $display("FAIL rst_ptr_zero gnt=%b exp=001", ifw2.gnt); end
    wait_cyc = 0;
    while (ifw2.ack === 3'b000 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    ifw2.req = 3'b000;
    checks++; if (ifw2.ack !== 3'b001) begin failures++; $display("FAIL rst_after_ack got=%b exp=001", ifw2.ack); end
    @(negedge clk);
    $display("txn w2 reset mid-write aborted");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    pre_en   = 1'b0;
    pre_sel  = 2'd0;
    pre_addr = 11'h000;
    pre_data = 16'h0000;
    ifw0.req = 3'b000; ifw0.we = 3'b000; ifw0.addr_in = '0; ifw0.wdata_in = '0;
    ifw1.req = 3'b000; ifw1.we = 3'b000; ifw1.addr_in = '0; ifw1.wdata_in = '0;
    ifw2.req = 3'b000; ifw2.we = 3'b000; ifw2.addr_in = '0; ifw2.wdata_in = '0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_no_preempt();
    test_wait0();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
